// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared types and constants for the ram_arb front end.
//   - state_t : power-state FSM encoding (RUN / SLP / WAKE)
//   - IDLE_W  : idle counter width, wide enough for the largest legal
//               IDLE_CYC value (255)
package ram_arb_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SLP  = 2'd1,
    WAKE = 2'd2
  } state_t;

  localparam int IDLE_W = 8;

endpackage

// File: rtl/ram_arb_if.sv
// ram_arb_if
//   Bundles the requester handshake, the RAM port and the sleep strobe of
//   ram_arb.
//   Requester side : REQ0/1, WR0/1, A0/1, D0/1 in; GNT0/1, RVALID0/1, RDATA out
//   RAM side       : RAM_EN, RAM_WR, RAM_A, RAM_D out; RAM_Q in
//   Power          : SLEEP out
//   slave  modport : used by ram_arb itself
//   master modport : used by whatever drives the requests and models the RAM
interface ram_arb_if #(
  parameter int AW = 2,
  parameter int DW = 3
);

  logic          REQ0, REQ1;
  logic          WR0, WR1;
  logic [AW-1:0] A0, A1;
  logic [DW-1:0] D0, D1;
  logic          GNT0, GNT1;
  logic          RVALID0, RVALID1;
  logic [DW-1:0] RDATA;
  logic          RAM_EN, RAM_WR;
  logic [AW-1:0] RAM_A;
  logic [DW-1:0] RAM_D;
  logic [DW-1:0] RAM_Q;
  logic          SLEEP;

  modport slave (
    input  REQ0, REQ1, WR0, WR1, A0, A1, D0, D1, RAM_Q,
    output GNT0, GNT1, RVALID0, RVALID1, RDATA,
           RAM_EN, RAM_WR, RAM_A, RAM_D, SLEEP
  );

  modport master (
    output REQ0, REQ1, WR0, WR1, A0, A1, D0, D1, RAM_Q,
    input  GNT0, GNT1, RVALID0, RVALID1, RDATA,
           RAM_EN, RAM_WR, RAM_A, RAM_D, SLEEP
  );

endinterface

// File: rtl/ram_arb_rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter, at most one grant per cycle.
//   CLK, RST : clock and asynchronous active-high reset
//   req[1:0] : request vector
//   en       : grants allowed this cycle (combinational gate)
//   gnt[1:0] : one-hot grant (combinational)
//   On a tie the requester that was not granted last wins. last resets to 1
//   so requester 0 takes the first tie.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last <= 1'b1;
    end else if (|gnt) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/ram_arb.sv
// ram_arb
//   Two-requester front end for the single-port synchronous low-power RAM.
//   CLK, RST : clock and asynchronous active-high reset
//   bus      : ram_arb_if.slave carrying the requester handshake
//              (REQ/WR/A/D in, GNT/RVALID/RDATA out), the RAM port
//              (RAM_EN/WR/A/D out, RAM_Q in) and the SLEEP strobe.
//   Requests are granted round-robin in RUN. After IDLE_CYC idle cycles the
//   block parks in SLP (SLEEP=1); a request then passes through one WAKE
//   recovery cycle before it can be granted.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int AW       = 2,
  parameter int DW       = 3,
  parameter int IDLE_CYC = 8
) (
  input  logic CLK,
  input  logic RST,
  ram_arb_if.slave bus
);

  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);
  localparam logic [IDLE_W-1:0] CNT_ONE   = IDLE_W'(1);

  state_t            state, state_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
  logic              any_req;
  logic              arb_en;
  logic [1:0]        gnt;
  logic              rvalid0_q, rvalid1_q;
  logic              sleep_q;

  assign any_req = bus.REQ0 | bus.REQ1;

  // Gating on RST keeps every combinational output at 0 while reset is held.
  assign arb_en = (state == RUN) && !RST;

  rr_arb2 u_rr_arb2 (
    .CLK (CLK),
    .RST (RST),
    .req ({bus.REQ1, bus.REQ0}),
    .en  (arb_en),
    .gnt (gnt)
  );

  // A request in the counter's final cycle still counts as activity, so it
  // cancels the sleep entry and is granted in that same cycle.
  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    case (state)
      RUN: begin
        if (any_req) begin
          idle_cnt_nxt = '0;
        end else begin
          if (idle_cnt == IDLE_LAST) state_nxt = SLP;
          if (idle_cnt != '1) idle_cnt_nxt = idle_cnt + CNT_ONE;
        end
      end
      SLP: begin
        if (any_req) state_nxt = WAKE;
      end
      WAKE: begin
        state_nxt    = RUN;
        idle_cnt_nxt = '0;
      end
      default: begin
        state_nxt    = RUN;
        idle_cnt_nxt = '0;
      end
    endcase
  end

  // SLEEP is registered from the next state so it is high exactly while in SLP.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RUN;
      idle_cnt  <= '0;
      sleep_q   <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      idle_cnt  <= idle_cnt_nxt;
      sleep_q   <= (state_nxt == SLP);
      rvalid0_q <= gnt[0] & ~bus.WR0;
      rvalid1_q <= gnt[1] & ~bus.WR1;
    end
  end

  // RAM port follows the granted requester and idles at all-zero otherwise.
  always_comb begin
    bus.RAM_WR = 1'b0;
    bus.RAM_A  = '0;
    bus.RAM_D  = '0;
    if (gnt[0]) begin
      bus.RAM_WR = bus.WR0;
      bus.RAM_A  = bus.A0;
      bus.RAM_D  = bus.D0;
    end else if (gnt[1]) begin
      bus.RAM_WR = bus.WR1;
      bus.RAM_A  = bus.A1;
      bus.RAM_D  = bus.D1;
    end
  end

  assign bus.GNT0    = gnt[0];
  assign bus.GNT1    = gnt[1];
  assign bus.RAM_EN  = |gnt;
  assign bus.RVALID0 = rvalid0_q;
  assign bus.RVALID1 = rvalid1_q;
  assign bus.SLEEP   = sleep_q;
  assign bus.RDATA   = RST ? '0 : bus.RAM_Q;

endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb
//   Bench for ram_arb. Drives directed request vectors, models the external
//   single-port RAM, and checks read returns through a scoreboard queue that
//   a separate monitor drains whenever RVALID0/RVALID1 is seen.
module tb_ram_arb;

  localparam int AW       = 2;
  localparam int DW       = 3;
  localparam int IDLE_CYC = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  ram_arb_if #(.AW(AW), .DW(DW)) bus ();

  ram_arb #(.AW(AW), .DW(DW), .IDLE_CYC(IDLE_CYC)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // External synchronous RAM: write or registered read at the rising edge.
  logic [DW-1:0] ramMem [4] = '{default: '0};

  always @(posedge CLK) begin
    if (bus.RAM_EN) begin
      if (bus.RAM_WR) ramMem[bus.RAM_A] <= bus.RAM_D;
      else            bus.RAM_Q <= ramMem[bus.RAM_A];
    end
  end

  // Cycle index, advanced at every rising edge.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] expMem [4] = '{default: '0};
  int            testsRun = 0;
  int            failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic driveInputs(input logic r0, input logic w0, input logic [AW-1:0] a0,
                             input logic [DW-1:0] d0, input logic r1, input logic w1,
                             input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.REQ0 = r0; bus.WR0 = w0; bus.A0 = a0; bus.D0 = d0;
    bus.REQ1 = r1; bus.WR1 = w1; bus.A1 = a1; bus.D1 = d1;
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_gnt0"},    32'(bus.GNT0),    32'd0);
    checkOutput({name, "_gnt1"},    32'(bus.GNT1),    32'd0);
    checkOutput({name, "_ram_en"},  32'(bus.RAM_EN),  32'd0);
    checkOutput({name, "_ram_wr"},  32'(bus.RAM_WR),  32'd0);
    checkOutput({name, "_ram_a"},   32'(bus.RAM_A),   32'd0);
    checkOutput({name, "_ram_d"},   32'(bus.RAM_D),   32'd0);
    checkOutput({name, "_rvalid0"}, 32'(bus.RVALID0), 32'd0);
    checkOutput({name, "_rvalid1"}, 32'(bus.RVALID1), 32'd0);
    checkOutput({name, "_sleep"},   32'(bus.SLEEP),   32'd0);
  endtask

  // One cycle of stimulus: drive just after the edge, then check the
  // combinational grant/RAM outputs and the registered SLEEP in that cycle.
  task automatic applyStimulus(input string name,
                               input logic r0, input logic w0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0,
                               input logic r1, input logic w1, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d1,
                               input logic eg0, input logic eg1, input logic es);
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(posedge CLK);
    #1;
    driveInputs(r0, w0, a0, d0, r1, w1, a1, d1);
    #1;
    ew = 1'b0; ea = '0; ed = '0;
    if (eg0) begin
      ew = w0; ea = a0; ed = d0;
    end else if (eg1) begin
      ew = w1; ea = a1; ed = d1;
    end
    checkOutput({name, "_gnt0"},   32'(bus.GNT0),   32'(eg0));
    checkOutput({name, "_gnt1"},   32'(bus.GNT1),   32'(eg1));
    checkOutput({name, "_ram_en"}, 32'(bus.RAM_EN), 32'(eg0 | eg1));
    checkOutput({name, "_ram_wr"}, 32'(bus.RAM_WR), 32'(ew));
    checkOutput({name, "_ram_a"},  32'(bus.RAM_A),  32'(ea));
    checkOutput({name, "_ram_d"},  32'(bus.RAM_D),  32'(ed));
    checkOutput({name, "_sleep"},  32'(bus.SLEEP),  32'(es));
    if (eg0) begin
      if (w0) expMem[a0] = d0;
      else    sb.push_back('{idx: 0, data: expMem[a0], cyc: cyc + 1});
    end
    if (eg1) begin
      if (w1) expMem[a1] = d1;
      else    sb.push_back('{idx: 1, data: expMem[a1], cyc: cyc + 1});
    end
  endtask

  task automatic idleCycle(input string name, input logic es);
    applyStimulus(name, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, es);
  endtask

  // Monitor: every read return must match the head of the scoreboard in
  // port, data and cycle; an overdue head entry counts as a missing RVALID.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (bus.RVALID0 === 1'b1 || bus.RVALID1 === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("rvalid_unexpected", 32'({bus.RVALID1, bus.RVALID0}), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rvalid_port",  32'({bus.RVALID1, bus.RVALID0}), (e.idx == 1) ? 32'd2 : 32'd1);
          checkOutput("rdata",        32'(bus.RDATA), 32'(e.data));
          checkOutput("rvalid_cycle", 32'(cyc),       32'(e.cyc));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checkOutput("rvalid_missing", 32'({bus.RVALID1, bus.RVALID0}), (e.idx == 1) ? 32'd2 : 32'd1);
      end
    end
  end

  initial begin : stimulus
    // Power-on reset with both requesters active: outputs must stay forced to 0.
    driveInputs(1'b1, 1'b1, 2'd3, 3'd7, 1'b1, 1'b0, 2'd1, 3'd2);
    #1 RST = 1'b1;
    #2 checkResetOutputs("por");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    driveInputs(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);

    // Write from requester 0, then read it back through requester 1.
    applyStimulus("t1_wr", 1'b1, 1'b1, 2'd2, 3'd5, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("t1_rd", 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd2, 3'd0, 1'b0, 1'b1, 1'b0);
    idleCycle("t1_idle", 1'b0);

    // Both requesters read continuously: strict 0,1,0,1,0,1 alternation.
    for (int i = 0; i < 3; i++) begin
      applyStimulus("tie_a", 1'b1, 1'b0, 2'd2, 3'd0, 1'b1, 1'b0, 2'd1, 3'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus("tie_b", 1'b1, 1'b0, 2'd2, 3'd0, 1'b1, 1'b0, 2'd1, 3'd0, 1'b0, 1'b1, 1'b0);
    end

    // Fill all four addresses from alternating requesters, then read back.
    applyStimulus("fill0", 1'b1, 1'b1, 2'd0, 3'd6, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("fill1", 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b1, 2'd1, 3'd3, 1'b0, 1'b1, 1'b0);
    applyStimulus("fill2", 1'b1, 1'b1, 2'd2, 3'd4, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("fill3", 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b1, 2'd3, 3'd7, 1'b0, 1'b1, 1'b0);
    applyStimulus("back0", 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("back1", 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd1, 3'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus("back2", 1'b1, 1'b0, 2'd2, 3'd0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("back3", 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd3, 3'd0, 1'b0, 1'b1, 1'b0);

    // Seven idle cycles, then a request in the would-be expiry cycle.
    for (int i = 0; i < IDLE_CYC - 1; i++) idleCycle("near_idle", 1'b0);
    applyStimulus("near_req", 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd3, 3'd0, 1'b0, 1'b1, 1'b0);

    // Full idle run: SLEEP rises after IDLE_CYC cycles.
    for (int i = 0; i < IDLE_CYC; i++) idleCycle("sleep_idle", 1'b0);
    idleCycle("sleep_on0", 1'b1);
    idleCycle("sleep_on1", 1'b1);

    // Wake: request in s, WAKE in s+1, grant in s+2.
    applyStimulus("wake_s",  1'b1, 1'b0, 2'd1, 3'd0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus("wake_s1", 1'b1, 1'b0, 2'd1, 3'd0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus("wake_s2", 1'b1, 1'b0, 2'd1, 3'd0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0);

    // Read grant to requester 0, then reset in the following cycle.
    applyStimulus("pre_rst", 1'b1, 1'b0, 2'd2, 3'd0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    sb.delete();
    driveInputs(1'b1, 1'b1, 2'd3, 3'd7, 1'b1, 1'b0, 2'd1, 3'd2);
    #1 checkResetOutputs("mid_rst");
    @(negedge CLK);
    checkResetOutputs("mid_rst_hold");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    driveInputs(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);

    // After release the first tie goes to requester 0 again.
    applyStimulus("post_tie", 1'b1, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("post_tie2", 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd3, 3'd0, 1'b0, 1'b1, 1'b0);
    idleCycle("drain0", 1'b0);
    idleCycle("drain1", 1'b0);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/ram_arb.md
# ram_arb

Two-requester front end for the single-port synchronous `ram` in the low-power library. It arbitrates read/write requests round-robin onto the RAM's `EN`/`WR`/`A`/`D` port and returns read data with a valid strobe. After a run of idle cycles it raises `SLEEP` so the RAM clock/retention logic can be gated. On wake it inserts one recovery cycle before issuing the next access.

## Interface
Parameters:
- `AW`, 2, address width; matches `ram` `AW`
- `DW`, 3, data width; matches `ram` `DW`
- `IDLE_CYC`, 8, consecutive idle cycles before sleep; legal range 1..255

Ports:
- `CLK`  in  1  single clock, rising edge
- `RST`  in  1  asynchronous, active-high reset
- `REQ0`, `REQ1`  in  1  request from requester 0 / 1
- `WR0`, `WR1`  in  1  1 = write, 0 = read
- `A0`, `A1`  in  AW  request address
- `D0`, `D1`  in  DW  write data
- `GNT0`, `GNT1`  out  1  request accepted this cycle (combinational)
- `RVALID0`, `RVALID1`  out  1  read data valid (registered)
- `RDATA`  out  DW  read data; passes `RAM_Q` straight through
- `RAM_EN`, `RAM_WR`  out  1  to `ram` `EN`, `WR`
- `RAM_A`  out  AW  to `ram` `A`
- `RAM_D`  out  DW  to `ram` `D`
- `RAM_Q`  in  DW  from `ram` `Q`
- `SLEEP`  out  1  RAM may be clock-gated (registered)

## Operation
**Handshake**
- A requester holds `REQi`, `WRi`, `Ai` and `Di` stable until it samples `GNTi`=1 at a rising edge.
- One grant per cycle, at most.

**FSM** (state held in flops):
- `RUN` (reset state): grants are allowed.
  - Any `REQ` clears the idle counter.
  - No `REQ` increments the idle counter, saturating.
  - When the counter reaches `IDLE_CYC-1` in a cycle with no `REQ`, the next state is `SLP`.
- `SLP`: `SLEEP`=1, no grants, `RAM_EN`=0. Any `REQ` moves to `WAKE`.
- `WAKE`: `SLEEP`=0, no grants. Next state is unconditionally `RUN`, with the idle counter cleared.

**Arbitration** (in `RUN` only):
- With one `REQ`, that requester is granted.
- With both, the requester other than `LAST` is granted.
- `LAST` updates to the granted index on every grant.
- Reset value of `LAST` is 1, so requester 0 wins the first tie.

**RAM drive**
- `RAM_EN`=`GNT0|GNT1`.
- `RAM_WR`, `RAM_A` and `RAM_D` are muxed from the granted requester.
- When there is no grant, `RAM_WR`, `RAM_A` and `RAM_D` are 0.

**Read return**
- A granted read sets `RVALIDi`=1 in the following cycle, for one cycle.
- A granted write produces no `RVALID`.

**Reset values**
- Outputs: `GNT0/1`=0, `RAM_EN`=0, `RAM_WR`=0, `RAM_A`=0, `RAM_D`=0, `RVALID0/1`=0, `SLEEP`=0.
- Internal state: state=`RUN`, idle counter=0, `LAST`=1.
- While `RST` is high, all combinational outputs are forced to 0.
- Reset asserted mid-access drops any pending `RVALID`. The RAM contents are not touched.

## Timing
**Awake path**
- Cycle t: `REQi` in `RUN` gives `GNTi`=1 and `RAM_EN`=1 in t.
- The RAM performs the access at the edge ending t.
- `RVALIDi`=1 and `RDATA`=`mem[A]` in t+1.

**Sleep path**
- Back-to-back grants are possible every cycle.
- With no `REQ` from cycle t0, `SLEEP` rises in cycle t0+`IDLE_CYC`.
- A `REQ` arriving in `SLP` during cycle s:
  - `WAKE` in s+1 (`SLEEP`=0).
  - `RUN` in s+2, with `GNT` in s+2.
  - Request-to-grant latency is therefore 2 cycles.

**Boundary cases**
- A `REQ` arriving in the cycle the counter would expire cancels sleep; the grant is issued the same cycle.
- Simultaneous requests alternate strictly. A continuously requesting pair gets grants 0,1,0,1,…
- A single persistent requester is granted every cycle.

## Structure
- Package `ram_arb_pkg` holds:
  - state enum (`RUN`=2'd0, `SLP`=2'd1, `WAKE`=2'd2)
  - idle-counter width constant (8 bits, sized to the maximum `IDLE_CYC`)
- Sub-module `rr_arb2` contains the two-way round-robin.
  - Inputs: `req[1:0]`, `en`
  - Outputs: `gnt[1:0]`
  - Internal: `LAST` flop, with `CLK`/`RST`
- The top level holds the FSM, idle counter, RAM mux and `RVALID` flops.

## Test plan
- After reset, write `REQ0`, `A0`=2, `D0`=5; then read `REQ1`, `A1`=2.
  - Expect `GNT0` in cycle 0 and `GNT1` in cycle 1.
  - Expect `RVALID1`=1 with `RDATA`=5 in cycle 2.
- Hold both requesters requesting reads for 6 cycles.
  - Grants are 0,1,0,1,0,1.
  - `RVALID` alternates one cycle later.
  - `RAM_EN` is high in all 6 cycles.
- Idle for `IDLE_CYC`=8 cycles: `SLEEP` rises in cycle 8.
  - Then assert `REQ0` in cycle s.
  - `SLEEP` falls in s+1, `GNT0` in s+2, never earlier.
- Idle for 7 cycles, then `REQ1` in cycle 7: `GNT1` in cycle 7 and `SLEEP` never asserts.
- Assert `RST` in the cycle after a read grant.
  - `RVALID` stays 0 and all outputs go to 0.
  - After release, requester 0 wins the first tie.
- Write all 4 addresses with distinct values from alternating requesters, then read all 4 back: every `RDATA` matches.
